// File: rtl/i2s_sai_endpoint.sv
// I2S/SAI far-end endpoint: oversamples BCLK/LRCLK/SDATA in the SAICLK domain,
// locks to the 64-bit frame, assembles RX I/Q samples and serialises TX I/Q words.
module i2s_sai_endpoint #(
  parameter int RX_WIDTH  = 24,
  parameter int TX_WIDTH  = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic                SAICLK,
  input  logic                reset,
  input  logic                bclk_in,
  input  logic                lrclk_in,
  input  logic                sdata_in,
  output logic                sdata_out,
  output logic [RX_WIDTH-1:0] rx_left,
  output logic [RX_WIDTH-1:0] rx_right,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_left,
  input  logic [TX_WIDTH-1:0] tx_right,
  input  logic                tx_load,
  output logic                tx_ready,
  output logic                tx_underrun,
  output logic                locked,
  output logic                frame_err
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int PAD        = SLOT_BITS - TX_WIDTH;

  localparam logic [CW-1:0] LAST_BIT    = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] LR_HI_FIRST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] LR_HI_LAST  = CW'(FRAME_BITS - 2);
  localparam logic [CW-1:0] RX_L_END    = CW'(RX_WIDTH);
  localparam logic [CW-1:0] RX_R_FIRST  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] RX_R_END    = CW'(SLOT_BITS + RX_WIDTH);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // [0],[1] synchroniser stages, [2] history stage
  logic [2:0]            bclk_pipe_q, bclk_pipe_d;
  logic [2:0]            lr_pipe_q, lr_pipe_d;
  logic [2:0]            sd_pipe_q, sd_pipe_d;
  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  lr_prev_q, lr_prev_d;
  logic [RX_WIDTH-1:0]   left_sr_q, left_sr_d;
  logic [RX_WIDTH-1:0]   right_sr_q, right_sr_d;
  logic [RX_WIDTH-1:0]   rx_left_q, rx_left_d;
  logic [RX_WIDTH-1:0]   rx_right_q, rx_right_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [TX_WIDTH-1:0]   hold_l_q, hold_l_d;
  logic [TX_WIDTH-1:0]   hold_r_q, hold_r_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
  logic                  sdata_out_q, sdata_out_d;
  logic                  locked_q, locked_d;
  logic                  frame_err_q, frame_err_d;

  logic bclk_rise;
  logic bclk_fall;
  logic lr_smp;
  logic sd_smp;
  logic exp_lr;
  logic boundary;

  assign bclk_rise = bclk_pipe_q[1] & ~bclk_pipe_q[2];
  assign bclk_fall = ~bclk_pipe_q[1] & bclk_pipe_q[2];
  // LRCLK/SDATA taken from the history stage: their value while BCLK was still low
  assign lr_smp    = lr_pipe_q[2];
  assign sd_smp    = sd_pipe_q[2];

  // Frame tracking, RX assembly, TX handshake and serialisation
  always_comb begin
    bclk_pipe_d   = {bclk_pipe_q[1:0], bclk_in};
    lr_pipe_d     = {lr_pipe_q[1:0], lrclk_in};
    sd_pipe_d     = {sd_pipe_q[1:0], sdata_in};
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    lr_prev_d     = lr_prev_q;
    left_sr_d     = left_sr_q;
    right_sr_d    = right_sr_q;
    rx_left_d     = rx_left_q;
    rx_right_d    = rx_right_q;
    rx_valid_d    = 1'b0;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    tx_ready_d    = tx_ready_q;
    tx_underrun_d = 1'b0;
    tx_sr_d       = tx_sr_q;
    sdata_out_d   = sdata_out_q;
    frame_err_d   = 1'b0;
    boundary      = 1'b0;
    exp_lr        = (bit_cnt_q >= LR_HI_FIRST) && (bit_cnt_q <= LR_HI_LAST);

    if (bclk_rise) begin
      lr_prev_d = lr_smp;
      case (state_q)
        HUNT: begin
          if (lr_prev_q && !lr_smp) begin
            state_d   = RUN;
            bit_cnt_d = {CW{1'b0}};
            boundary  = 1'b1;
          end else begin
            state_d = HUNT;
          end
        end
        RUN: begin
          if (lr_smp != exp_lr) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
            bit_cnt_d   = {CW{1'b0}};
          end else begin
            if (bit_cnt_q < RX_L_END) begin
              left_sr_d = {left_sr_q[RX_WIDTH-2:0], sd_smp};
            end else if ((bit_cnt_q >= RX_R_FIRST) && (bit_cnt_q < RX_R_END)) begin
              right_sr_d = {right_sr_q[RX_WIDTH-2:0], sd_smp};
            end else begin
              left_sr_d = left_sr_q;
            end
            if (bit_cnt_q == LAST_BIT) begin
              boundary   = 1'b1;
              bit_cnt_d  = {CW{1'b0}};
              rx_left_d  = left_sr_q;
              rx_right_d = right_sr_q;
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d   = HUNT;
          bit_cnt_d = {CW{1'b0}};
        end
      endcase
    end else if (bclk_fall) begin
      if (state_q == RUN) begin
        sdata_out_d = tx_sr_q[FRAME_BITS-1];
        tx_sr_d     = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
      end else begin
        sdata_out_d = 1'b0;
      end
    end else begin
      sdata_out_d = sdata_out_q;
    end

    // Boundary is resolved before a coincident load so an empty holding still underruns
    if (boundary) begin
      if (!tx_ready_q) begin
        tx_sr_d    = {hold_l_q, {PAD{1'b0}}, hold_r_q, {PAD{1'b0}}};
        tx_ready_d = 1'b1;
      end else begin
        tx_sr_d       = {FRAME_BITS{1'b0}};
        tx_underrun_d = 1'b1;
      end
    end else begin
      tx_underrun_d = 1'b0;
    end

    if (tx_load && tx_ready_q) begin
      hold_l_d   = tx_left;
      hold_r_d   = tx_right;
      tx_ready_d = 1'b0;
    end else begin
      hold_l_d = hold_l_q;
    end

    locked_d = (state_d == RUN);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge SAICLK) begin
    if (!reset) begin
      bclk_pipe_q   <= 3'b000;
      lr_pipe_q     <= 3'b000;
      sd_pipe_q     <= 3'b000;
      state_q       <= HUNT;
      bit_cnt_q     <= {CW{1'b0}};
      lr_prev_q     <= 1'b0;
      left_sr_q     <= {RX_WIDTH{1'b0}};
      right_sr_q    <= {RX_WIDTH{1'b0}};
      rx_left_q     <= {RX_WIDTH{1'b0}};
      rx_right_q    <= {RX_WIDTH{1'b0}};
      rx_valid_q    <= 1'b0;
      hold_l_q      <= {TX_WIDTH{1'b0}};
      hold_r_q      <= {TX_WIDTH{1'b0}};
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
      tx_sr_q       <= {FRAME_BITS{1'b0}};
      sdata_out_q   <= 1'b0;
      locked_q      <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      bclk_pipe_q   <= bclk_pipe_d;
      lr_pipe_q     <= lr_pipe_d;
      sd_pipe_q     <= sd_pipe_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      lr_prev_q     <= lr_prev_d;
      left_sr_q     <= left_sr_d;
      right_sr_q    <= right_sr_d;
      rx_left_q     <= rx_left_d;
      rx_right_q    <= rx_right_d;
      rx_valid_q    <= rx_valid_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      tx_sr_q       <= tx_sr_d;
      sdata_out_q   <= sdata_out_d;
      locked_q      <= locked_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign sdata_out   = sdata_out_q;
  assign rx_left     = rx_left_q;
  assign rx_right    = rx_right_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign locked      = locked_q;
  assign frame_err   = frame_err_q;

endmodule
